// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the miniRV fetch front end.
// Provides a valid/ready fetch request, sequential PC increment by STEP,
// trap/redirect steering, stall, halt/resume and an accepted-fetch counter.
// Optional feature macro: PC_MISALIGN_CHECK_EN. When it is defined, a
// misaligned redirect is steered to trap_vec and misalign_err pulses.
// When it is undefined, the redirect target is aligned down and
// misalign_err stays 0.
//
// Handshake: fetch_valid/fetch_pc form the request; a fetch is accepted in
// any cycle where fetch_valid && fetch_ready. While fetch_valid is high
// without ready, fetch_pc holds. A change of fetch_pc under valid (trap or
// redirect) abandons the pending request and must be treated as a flush.
module pc_gen #(
   parameter int unsigned       XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000,
   parameter int unsigned       STEP     = 4,
   parameter int unsigned       CNT_W    = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   output logic             fetch_valid,
   input  logic             fetch_ready,
   output logic [XLEN-1:0]  fetch_pc,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   input  logic             trap_valid,
   input  logic [XLEN-1:0]  trap_vec,
   input  logic             halt_req,
   output logic             halted,
   output logic             misalign_err,
   output logic [CNT_W-1:0] fetch_count,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   // Mask that clears the low log2(STEP) address bits.
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(STEP) - XLEN'(1));

   state_t           state, state_nxt;
   logic [XLEN-1:0]  pc_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic             misalign_nxt;
   logic             accept;
   logic [XLEN-1:0]  trap_tgt;
   logic             redir_misaligned;

   assign fetch_valid      = (state == RUN) && !stall;
   assign accept           = fetch_valid && fetch_ready;
   assign halted           = (state == HALTED);
   assign state_dbg        = state;
   assign trap_tgt         = trap_vec & ALIGN_MASK;
   assign redir_misaligned = |(redirect_pc & ~ALIGN_MASK);

   // Next-state, next-PC and counter selection.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = fetch_pc;
      count_nxt    = fetch_count;
      misalign_nxt = 1'b0;

      // An accepted fetch always counts, even when the PC is steered away.
      if (accept) begin
         count_nxt = fetch_count + CNT_W'(1);
      end

      if (trap_valid) begin
         pc_nxt = trap_tgt;
      end else if (redirect_valid) begin
`ifdef PC_MISALIGN_CHECK_EN
         if (redir_misaligned) begin
            pc_nxt       = trap_tgt;
            misalign_nxt = 1'b1;
         end else begin
            pc_nxt = redirect_pc;
         end
`else
         pc_nxt = redirect_pc & ALIGN_MASK;
`endif
      end else if (accept) begin
         pc_nxt = fetch_pc + XLEN'(STEP);
      end

      case (state)
         BOOT: begin
            // halt_req is deliberately ignored here.
            state_nxt = RUN;
         end
         RUN: begin
            if (halt_req) begin
               state_nxt = HALTED;
            end
         end
         HALTED: begin
            // Only a trap or redirect resumes; a still-high halt_req keeps us here.
            if ((trap_valid || redirect_valid) && !halt_req) begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   // State, PC, counter and misalign pulse registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= BOOT;
         fetch_pc     <= RESET_PC;
         fetch_count  <= '0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         fetch_pc     <= pc_nxt;
         fetch_count  <= count_nxt;
         misalign_err <= misalign_nxt;
      end
   end

   // Only referenced when the misalign check is compiled in.
   logic unused_ok;
   assign unused_ok = redir_misaligned;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: table-driven directed test of pc_gen (XLEN=32, STEP=4),
// plus hand-written sequences for async reset and halt_req during BOOT.
module tb_pc_gen;

   logic        clock;
   logic        reset_n;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_pc;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        trap_valid;
   logic [31:0] trap_vec;
   logic        halt_req;
   logic        halted;
   logic        misalign_err;
   logic [31:0] fetch_count;
   logic [1:0]  state_dbg;

   int n_cmp  = 0;
   int n_fail = 0;

   pc_gen #(
      .XLEN(32), .RESET_PC(32'h8000_0000), .STEP(4), .CNT_W(32)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .trap_valid(trap_valid), .trap_vec(trap_vec), .halt_req(halt_req),
      .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count),
      .state_dbg(state_dbg)
   );

   // Clock generation.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        stall;
      logic        ready;
      logic        rv;
      logic [31:0] rpc;
      logic        tv;
      logic [31:0] tvec;
      logic        halt;
      logic        e_valid;
      logic [31:0] e_pc;
      logic        e_halted;
      logic [31:0] e_cnt;
      logic        e_mis;
   } vec_t;

   localparam int NV = 25;
   vec_t tbl [NV];

   function automatic vec_t mk(logic st, logic rdy, logic rv, logic [31:0] rpc,
                               logic tv, logic [31:0] tvec, logic hlt,
                               logic ev, logic [31:0] epc, logic eh,
                               logic [31:0] ecnt, logic emis);
      vec_t v;
      v.stall = st; v.ready = rdy; v.rv = rv; v.rpc = rpc; v.tv = tv;
      v.tvec = tvec; v.halt = hlt; v.e_valid = ev; v.e_pc = epc;
      v.e_halted = eh; v.e_cnt = ecnt; v.e_mis = emis;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_outputs(input string tag, input logic ev, input logic [31:0] epc,
                              input logic eh, input logic [31:0] ecnt, input logic emis);
      chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(ev));
      chk({tag, ".fetch_pc"}, fetch_pc, epc);
      chk({tag, ".halted"}, 32'(halted), 32'(eh));
      chk({tag, ".fetch_count"}, fetch_count, ecnt);
      chk({tag, ".misalign_err"}, 32'(misalign_err), 32'(emis));
   endtask

   task automatic drive_idle();
      stall = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0;
      redirect_pc = 32'h0; trap_valid = 1'b0; trap_vec = 32'h8000_0100;
      halt_req = 1'b0;
   endtask

   task automatic drive_vec(input vec_t v);
      stall = v.stall; fetch_ready = v.ready; redirect_valid = v.rv;
      redirect_pc = v.rpc; trap_valid = v.tv; trap_vec = v.tvec;
      halt_req = v.halt;
   endtask

   localparam logic [31:0] TV = 32'h8000_0100;

   initial begin
      logic [31:0] mis_pc;
      logic        mis_pulse;
`ifdef PC_MISALIGN_CHECK_EN
      mis_pc    = TV;
      mis_pulse = 1'b1;
`else
      mis_pc    = 32'h8000_0400;
      mis_pulse = 1'b0;
`endif
      // Expected values are the outputs sampled just after the edge,
      // with the vector's inputs still applied.
      //            st rdy rv rpc           tv tvec          hlt  ev pc            h  cnt emis
      tbl[0]  = mk(0, 1, 0, 32'h0,         0, TV,           0,   1, 32'h8000_0000, 0, 0, 0);
      tbl[1]  = mk(0, 1, 0, 32'h0,         0, TV,           0,   1, 32'h8000_0004, 0, 1, 0);
      tbl[2]  = mk(0, 1, 0, 32'h0,         0, TV,           0,   1, 32'h8000_0008, 0, 2, 0);
      tbl[3]  = mk(0, 1, 0, 32'h0,         0, TV,           0,   1, 32'h8000_000C, 0, 3, 0);
      tbl[4]  = mk(0, 0, 1, 32'h8000_0008, 0, TV,           0,   1, 32'h8000_0008, 0, 3, 0);
      tbl[5]  = mk(0, 0, 0, 32'h0,         0, TV,           0,   1, 32'h8000_0008, 0, 3, 0);
      tbl[6]  = mk(0, 0, 0, 32'h0,         0, TV,           0,   1, 32'h8000_0008, 0, 3, 0);
      tbl[7]  = mk(0, 0, 0, 32'h0,         0, TV,           0,   1, 32'h8000_0008, 0, 3, 0);
      tbl[8]  = mk(0, 1, 0, 32'h0,         0, TV,           0,   1, 32'h8000_000C, 0, 4, 0);
      tbl[9]  = mk(0, 1, 1, 32'h8000_2000, 1, TV,           0,   1, 32'h8000_0100, 0, 5, 0);
      tbl[10] = mk(1, 1, 0, 32'h0,         0, TV,           0,   0, 32'h8000_0100, 0, 5, 0);
      tbl[11] = mk(1, 1, 0, 32'h0,         0, TV,           0,   0, 32'h8000_0100, 0, 5, 0);
      tbl[12] = mk(0, 0, 0, 32'h0,         0, TV,           0,   1, 32'h8000_0100, 0, 5, 0);
      tbl[13] = mk(0, 1, 0, 32'h0,         0, TV,           1,   0, 32'h8000_0104, 1, 6, 0);
      tbl[14] = mk(0, 1, 0, 32'h0,         0, TV,           0,   0, 32'h8000_0104, 1, 6, 0);
      tbl[15] = mk(0, 1, 1, 32'h8000_0400, 0, TV,           0,   1, 32'h8000_0400, 0, 6, 0);
      tbl[16] = mk(0, 0, 1, 32'h8000_0402, 0, TV,           0,   1, mis_pc,        0, 6, mis_pulse);
      tbl[17] = mk(0, 0, 0, 32'h0,         0, TV,           0,   1, mis_pc,        0, 6, 0);
      tbl[18] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, TV,           0,   1, 32'hFFFF_FFFC, 0, 6, 0);
      tbl[19] = mk(0, 1, 0, 32'h0,         0, TV,           0,   1, 32'h0000_0000, 0, 7, 0);
      tbl[20] = mk(0, 0, 0, 32'h0,         1, 32'h8000_0203, 0,  1, 32'h8000_0200, 0, 7, 0);
      tbl[21] = mk(0, 1, 0, 32'h0,         0, TV,           1,   0, 32'h8000_0204, 1, 8, 0);
      tbl[22] = mk(0, 1, 1, 32'h8000_0300, 0, TV,           1,   0, 32'h8000_0300, 1, 8, 0);
      tbl[23] = mk(0, 1, 0, 32'h0,         1, 32'h8000_0500, 0,  1, 32'h8000_0500, 0, 8, 0);
      tbl[24] = mk(0, 0, 1, 32'h8000_0402, 1, 32'h8000_0600, 0,  1, 32'h8000_0600, 0, 8, 0);

      // Reset phase.
      reset_n = 1'b0;
      drive_idle();
      #12;
      chk_outputs("reset", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
      chk("reset.state", 32'(state_dbg), 32'd0);

      @(negedge clock);
      reset_n = 1'b1;

      // Table vectors.
      for (int i = 0; i < NV; i++) begin
         drive_vec(tbl[i]);
         @(posedge clock);
         #1;
         chk_outputs($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_pc,
                     tbl[i].e_halted, tbl[i].e_cnt, tbl[i].e_mis);
         @(negedge clock);
      end

      // Mid-run asynchronous reset, away from any clock edge.
      drive_idle();
      #2;
      reset_n = 1'b0;
      #1;
      chk_outputs("async_rst", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
      chk("async_rst.state", 32'(state_dbg), 32'd0);

      // halt_req during BOOT is ignored; held into RUN it halts after one accept.
      @(negedge clock);
      reset_n  = 1'b1;
      halt_req = 1'b1;
      @(posedge clock);
      #1;
      chk_outputs("boot_halt", 1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
      chk("boot_halt.state", 32'(state_dbg), 32'd1);
      @(posedge clock);
      #1;
      chk_outputs("run_halt", 1'b0, 32'h8000_0004, 1'b1, 32'h1, 1'b0);
      chk("run_halt.state", 32'(state_dbg), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the miniRV fetch front end. It replaces the bare reset-to-vector PC register with several additions: a valid/ready fetch handshake, sequential increment by a configurable step, redirect and trap steering, stall, halt/resume, and an accepted-fetch counter. It sits between the execute/CSR logic, which supplies redirect and trap targets, and the instruction-memory request port.

## Interface
- XLEN, 32: PC width in bits.
- RESET_PC, 32'h8000_0000: fetch address after reset.
- STEP, 4: byte increment per accepted fetch; power of two, 2..8.
- CNT_W, 32: width of the accepted-fetch counter.

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_valid  out  1  fetch_pc is a live request.
- fetch_ready  in  1  memory accepts the request this cycle.
- fetch_pc  out  XLEN  current fetch address.
- stall  in  1  pipeline back-pressure; freezes PC and drops fetch_valid.
- redirect_valid  in  1  branch/jump/mret target present.
- redirect_pc  in  XLEN  redirect target.
- trap_valid  in  1  exception/interrupt taken.
- trap_vec  in  XLEN  trap handler address.
- halt_req  in  1  request entry to HALTED.
- halted  out  1  block is in HALTED.
- misalign_err  out  1  one-cycle pulse on a misaligned redirect (macro-dependent).
- fetch_count  out  CNT_W  number of accepted fetches, wrapping.

## Operation
- States: BOOT, RUN, HALTED.
  - BOOT is entered on reset and lasts exactly one cycle, then moves to RUN.
- fetch_valid = (state == RUN) && !stall.
- Handshake: a fetch is accepted when fetch_valid && fetch_ready.
  - On acceptance: fetch_pc += STEP, modulo 2^XLEN (wraps at the top of the address space) and fetch_count += 1 (wraps to 0).
  - While fetch_valid is high without ready, fetch_pc holds.
- Next-PC priority per cycle, highest first:
  1. trap_valid: fetch_pc <= trap_vec (low log2(STEP) bits forced 0).
  2. redirect_valid: fetch_pc <= redirect_pc.
  3. Accepted fetch: fetch_pc <= fetch_pc + STEP.
  4. Otherwise: hold.
- Trap and redirect act in BOOT, RUN and HALTED, and regardless of stall and fetch_ready.
- A pending unaccepted request is abandoned on trap/redirect; the memory side must treat a fetch_pc change under valid as a flush.
- A trap/redirect coincident with acceptance still counts the accepted fetch, but the new PC is the target, not +STEP.
- halt_req in RUN: move to HALTED at the next edge. If the same cycle has an acceptance, the increment and count still apply.
- HALTED: fetch_valid = 0, fetch_pc holds, halted = 1.
- Leaving HALTED: only redirect_valid or trap_valid, which load the target and move to RUN. If halt_req is still high at that time, the block stays HALTED but the PC is updated.
- halt_req in BOOT is ignored.

## Timing
- Reset values (async assert, while reset_n = 0):
  - fetch_pc = RESET_PC, fetch_valid = 0, halted = 0, misalign_err = 0, fetch_count = 0, state = BOOT.
- Reset is released synchronously to clock by the top level. First edge after release: BOOT→RUN, so fetch_valid = 1 from cycle 1.
- Trap/redirect sampled at edge N: the new fetch_pc is visible after edge N, with zero bubble cycles.
- stall is combinational to fetch_valid: same-cycle effect, no added latency.
- Reset asserted mid-operation aborts everything immediately: PC, state and counter return to reset values; any outstanding request is dropped.

## Configuration
- PC_MISALIGN_CHECK_EN defined:
  - A redirect_pc with nonzero low log2(STEP) bits does not load redirect_pc.
  - Instead it loads trap_vec (aligned) and pulses misalign_err high for one cycle after the edge.
  - trap_valid in the same cycle still takes priority and suppresses the pulse.
- PC_MISALIGN_CHECK_EN undefined:
  - The low log2(STEP) bits of redirect_pc are forced to 0.
  - misalign_err is tied to 0.

## Test plan
- Reset release, fetch_ready = 1 held: cycle 1 fetch_pc = 0x8000_0000 with valid; cycle 4 fetch_pc = 0x8000_000C; fetch_count = 3.
- fetch_ready = 0 for 3 cycles at 0x8000_0008, then 1: PC holds at 0x8000_0008 with valid high, then advances to 0x8000_000C; count increments once.
- Same-cycle trap_vec = 0x8000_0100 with redirect 0x8000_2000 and acceptance: next fetch_pc = 0x8000_0100 and count +1. Stall asserted for 2 cycles: fetch_valid = 0 and PC frozen during the stall.
- halt_req in RUN: halted = 1 and fetch_valid = 0 next cycle. Redirect 0x8000_0400 while halted: RUN resumes with fetch_pc = 0x8000_0400.
- With PC_MISALIGN_CHECK_EN, redirect 0x8000_0402: fetch_pc = trap_vec and misalign_err pulses for one cycle. Without the macro: fetch_pc = 0x8000_0400 and misalign_err stays 0.
- XLEN = 32, redirect 0xFFFF_FFFC then acceptance: fetch_pc wraps to 0x0000_0000. Assert reset_n low mid-run: fetch_pc = RESET_PC asynchronously and count = 0.
